// File: rtl/bmu_pkg.sv
// Shared types for the BMU request arbiter: opcodes, decoded operation flags,
// and the arbiter state encoding.
package bmu_pkg;

  localparam int NUM_OPS = 16;
  localparam int OPW     = 5;
  localparam int NUM_FN  = NUM_OPS;

  typedef enum logic [OPW-1:0] {
    ADD    = 5'd0,
    SUB    = 5'd1,
    SLT    = 5'd2,
    SH3ADD = 5'd3,
    AND    = 5'd4,
    XOR    = 5'd5,
    SLL    = 5'd6,
    SRA    = 5'd7,
    ROL    = 5'd8,
    BEXT   = 5'd9,
    CLZ    = 5'd10,
    CPOP   = 5'd11,
    SEXT_H = 5'd12,
    MIN    = 5'd13,
    PACKU  = 5'd14,
    GORC   = 5'd15
  } bmu_op_e;

  // One-hot function flag (bit index == opcode) plus the extension group flag.
  typedef struct packed {
    logic              zba;
    logic              zbb;
    logic              zbp;
    logic              zbs;
    logic [NUM_FN-1:0] fn;
  } bmu_ap_t;

  typedef enum logic [1:0] {
    EXT_ZBA,
    EXT_ZBB,
    EXT_ZBP,
    EXT_ZBS
  } ext_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  // Extension group each opcode is issued under.
  function automatic ext_e ext_of(bmu_op_e op);
    unique case (op)
      ADD, SUB, SLT, SH3ADD:                 return EXT_ZBA;
      AND, XOR, ROL, CLZ, CPOP, SEXT_H, MIN: return EXT_ZBB;
      PACKU, GORC:                           return EXT_ZBP;
      default:                               return EXT_ZBS;
    endcase
  endfunction

endpackage

// File: rtl/bmu_op_decode.sv
// Combinational opcode decoder: opcode -> one-hot function flag plus its
// extension flag; illegal opcodes decode to all-zero.
module bmu_op_decode #(
  parameter int NUM_OPS = bmu_pkg::NUM_OPS,
  parameter int OPW     = bmu_pkg::OPW
) (
  input  logic [OPW-1:0]   op,
  output logic             legal,
  output bmu_pkg::bmu_ap_t ap
);
  import bmu_pkg::*;

  bmu_op_e code;

  assign code  = bmu_op_e'(op);
  assign legal = (32'(op) < NUM_OPS);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    ap = '0;
    if (legal) begin
      ap.fn = NUM_FN'(1) << op;
      unique case (ext_of(code))
        EXT_ZBA: ap.zba = 1'b1;
        EXT_ZBB: ap.zbb = 1'b1;
        EXT_ZBP: ap.zbp = 1'b1;
        EXT_ZBS: ap.zbs = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/bmu_arbiter.sv
// Two-requester round-robin front end for a single BMU: accepts one operation
// at a time, issues it for one cycle, and returns the result to its owner.
module bmu_arbiter #(
  parameter int NUM_OPS = bmu_pkg::NUM_OPS,
  parameter int OPW     = bmu_pkg::OPW
) (
  input  logic             clk,
  input  logic             rst_l,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [OPW-1:0]   req0_op,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [OPW-1:0]   req1_op,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_error,

  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_error,

  output logic             bmu_valid_in,
  output logic [31:0]      bmu_a_in,
  output logic [31:0]      bmu_b_in,
  output bmu_pkg::bmu_ap_t bmu_ap,
  output logic             bmu_scan_mode,
  output logic             bmu_csr_ren_in,
  output logic [31:0]      bmu_csr_rddata_in,

  input  logic [31:0]      bmu_result_ff,
  input  logic             bmu_error
);
  import bmu_pkg::*;

  state_e         state_q;
  logic           gnt_q;
  logic           last_q;
  logic [31:0]    res_q;
  logic           err_q;

  logic           gnt_sel;
  logic           accept;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic [OPW-1:0] sel_op;
  logic           dec_legal;
  bmu_ap_t        dec_ap;

  // Round-robin: on a tie the requester not served last wins.
  always_comb begin
    gnt_sel = 1'b0;
    if (req0_valid && req1_valid) gnt_sel = ~last_q;
    else if (req1_valid)          gnt_sel = 1'b1;
  end

  // Ready is held low while reset is asserted, even if a requester is valid.
  assign accept     = rst_l && (state_q == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !gnt_sel;
  assign req1_ready = accept &&  gnt_sel;

  assign sel_a  = gnt_sel ? req1_a  : req0_a;
  assign sel_b  = gnt_sel ? req1_b  : req0_b;
  assign sel_op = gnt_sel ? req1_op : req0_op;

  bmu_op_decode #(
    .NUM_OPS (NUM_OPS),
    .OPW     (OPW)
  ) u_decode (
    .op    (sel_op),
    .legal (dec_legal),
    .ap    (dec_ap)
  );

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values and ordering between always_ff blocks is irrelevant.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= IDLE;
      gnt_q        <= 1'b0;
      last_q       <= 1'b1;
      res_q        <= '0;
      err_q        <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      bmu_valid_in <= 1'b0;
      bmu_a_in     <= '0;
      bmu_b_in     <= '0;
      bmu_ap       <= '0;
    end else begin
      bmu_valid_in <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            gnt_q <= gnt_sel;
            if (dec_legal) begin
              // Operands are captured into the BMU-facing registers here, so
              // later requester activity cannot disturb the op in flight.
              bmu_a_in     <= sel_a;
              bmu_b_in     <= sel_b;
              bmu_ap       <= dec_ap;
              bmu_valid_in <= 1'b1;
              state_q      <= ISSUE;
            end else begin
              res_q      <= '0;
              err_q      <= 1'b1;
              rsp0_valid <= !gnt_sel;
              rsp1_valid <=  gnt_sel;
              state_q    <= RESP;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          res_q      <= bmu_result_ff;
          err_q      <= bmu_error;
          rsp0_valid <= !gnt_q;
          rsp1_valid <=  gnt_q;
          state_q    <= RESP;
        end
        RESP: begin
          if (gnt_q ? rsp1_ready : rsp0_ready) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            last_q     <= gnt_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp0_result = res_q;
  assign rsp0_error  = err_q;
  assign rsp1_result = res_q;
  assign rsp1_error  = err_q;

  assign bmu_scan_mode     = 1'b0;
  assign bmu_csr_ren_in    = 1'b0;
  assign bmu_csr_rddata_in = '0;

endmodule

// File: tb/tb_bmu_arbiter.sv
// Directed bench for bmu_arbiter: a vector table of single operations plus
// hand sequences for arbitration order, backpressure and mid-op reset.
module tb_bmu_arbiter;
  import bmu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_error, rsp1_error;
  logic        bmu_valid_in;
  logic [31:0] bmu_a_in, bmu_b_in;
  bmu_ap_t     bmu_ap;
  logic        bmu_scan_mode, bmu_csr_ren_in;
  logic [31:0] bmu_csr_rddata_in;
  logic [31:0] bmu_result_ff = '0;
  logic        bmu_error = 1'b0;
  logic        err_next = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bmu_arbiter dut (
    .clk(clk), .rst_l(rst_l),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_error(rsp0_error),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_error(rsp1_error),
    .bmu_valid_in(bmu_valid_in), .bmu_a_in(bmu_a_in), .bmu_b_in(bmu_b_in), .bmu_ap(bmu_ap),
    .bmu_scan_mode(bmu_scan_mode), .bmu_csr_ren_in(bmu_csr_ren_in), .bmu_csr_rddata_in(bmu_csr_rddata_in),
    .bmu_result_ff(bmu_result_ff), .bmu_error(bmu_error)
  );

  // Stand-in BMU: result registered one cycle after the issue pulse.
  function automatic logic [31:0] bmu_model(logic [31:0] a, logic [31:0] b, bmu_ap_t ap);
    if (ap.fn[0]) return a + b;         // ADD
    if (ap.fn[1]) return a - b;         // SUB
    if (ap.fn[6]) return a << b[4:0];   // SLL
    return a ^ b;
  endfunction

  always @(posedge clk) begin
    if (bmu_valid_in) begin
      bmu_result_ff <= bmu_model(bmu_a_in, bmu_b_in, bmu_ap);
      bmu_error     <= err_next;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        err_in;
    logic [31:0] exp_res;
    logic        exp_err;
    logic        legal;
    logic [19:0] exp_ap;
  } vec_t;

  vec_t vecs[10];

  // One isolated operation from requester v.id; inputs are scrambled right
  // after accept so only the accepted values may reach the BMU and response.
  task automatic do_op(input vec_t v);
    int          k;
    int          lat;
    int          pulses;
    logic        seen;
    logic [19:0] ap_bits;
    lat = 0; pulses = 0; seen = 1'b0; k = 1;
    err_next = v.err_in;
    if (v.id == 0) begin
      req0_valid = 1'b1; req0_op = v.op; req0_a = v.a; req0_b = v.b;
    end else begin
      req1_valid = 1'b1; req1_op = v.op; req1_a = v.a; req1_b = v.b;
    end
    #1;
    check("ready_own",   32'(v.id == 0 ? req0_ready : req1_ready), 1);
    check("ready_other", 32'(v.id == 0 ? req1_ready : req0_ready), 0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~v.a; req1_a = ~v.a; req0_b = ~v.b; req1_b = ~v.b;
    req0_op = 5'd1; req1_op = 5'd1;
    while (!seen && k <= 8) begin
      if (bmu_valid_in) begin
        pulses++;
        ap_bits = bmu_ap;
        check("issue_cycle", k, 1);
        check("bmu_a_in", bmu_a_in, v.a);
        check("bmu_b_in", bmu_b_in, v.b);
        check("bmu_ap", 32'(ap_bits), 32'(v.exp_ap));
      end
      if (v.id == 0 ? rsp0_valid : rsp1_valid) begin
        seen = 1'b1;
        lat  = k;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    check("rsp_seen", 32'(seen), 1);
    check("rsp_latency", lat, v.legal ? 3 : 1);
    check("issue_pulses", pulses, v.legal ? 1 : 0);
    check("rsp_result", v.id == 0 ? rsp0_result : rsp1_result, v.exp_res);
    check("rsp_error", 32'(v.id == 0 ? rsp0_error : rsp1_error), 32'(v.exp_err));
    check("rsp_other_valid", 32'(v.id == 0 ? rsp1_valid : rsp0_valid), 0);
    if (v.id == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    check("rsp_dropped", 32'(rsp0_valid | rsp1_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   grants[$];
    int   exp_g[4];
    int   hits;
    logic [19:0] ap_bits;
    vec_t v;

    vecs[0] = '{0, ADD,    32'd5,         32'd7,     1'b0, 32'd12,        1'b0, 1'b1, 20'h80001};
    vecs[1] = '{1, SUB,    32'd10,        32'd3,     1'b0, 32'd7,         1'b0, 1'b1, 20'h80002};
    vecs[2] = '{0, XOR,    32'h0000_00F0, 32'h0F,    1'b0, 32'h0000_00FF, 1'b0, 1'b1, 20'h40020};
    vecs[3] = '{1, SLL,    32'd3,         32'd4,     1'b0, 32'h30,        1'b0, 1'b1, 20'h10040};
    vecs[4] = '{0, CLZ,    32'hF000_0000, 32'd3,     1'b0, 32'hF000_0003, 1'b0, 1'b1, 20'h40400};
    vecs[5] = '{1, GORC,   32'h0000_1234, 32'h00FF,  1'b0, 32'h0000_12CB, 1'b0, 1'b1, 20'h28000};
    vecs[6] = '{0, SUB,    32'd0,         32'd1,     1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 20'h80002};
    vecs[7] = '{1, 5'd20,  32'd1,         32'd2,     1'b0, 32'd0,         1'b1, 1'b0, 20'h0};
    vecs[8] = '{0, 5'd16,  32'd3,         32'd4,     1'b0, 32'd0,         1'b1, 1'b0, 20'h0};
    vecs[9] = '{1, 5'd31,  32'd5,         32'd6,     1'b0, 32'd0,         1'b1, 1'b0, 20'h0};
    exp_g = '{0, 1, 0, 1};

    // Reset state, with both requesters already valid.
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd1; req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = ADD; req1_a = 32'd3; req1_b = 32'd4;
    repeat (2) @(negedge clk);
    ap_bits = bmu_ap;
    check("rst_ready", 32'({req0_ready, req1_ready}), 0);
    check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 0);
    check("rst_bmu_valid", 32'(bmu_valid_in), 0);
    check("rst_bmu_a", bmu_a_in, 0);
    check("rst_bmu_ap", 32'(ap_bits), 0);
    check("rst_result", rsp0_result | rsp1_result, 0);
    check("rst_ties", 32'({bmu_scan_mode, bmu_csr_ren_in}) | bmu_csr_rddata_in, 0);

    // Round-robin from reset: both held valid, responses taken at once.
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    rst_l = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) check("ready_exclusive", 1, 0);
      else if (req0_ready) grants.push_back(0);
      else if (req1_ready) grants.push_back(1);
      @(negedge clk);
    end
    check("rr_grant_count", grants.size(), 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) check($sformatf("rr_grant%0d", i), grants[i], exp_g[i]);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (6) @(negedge clk);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    foreach (vecs[i]) do_op(vecs[i]);

    // Backpressure: rsp0 held for 5 cycles while req1 waits.
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd100; req0_b = 32'd23;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op = ADD; req1_a = 32'd1; req1_b = 32'd1;
    for (int c = 0; c < 8 && !rsp0_valid; c++) begin
      check("bp_req1_blocked", 32'(req1_ready), 0);
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp0_valid", 32'(rsp0_valid), 1);
      check("bp_rsp0_result", rsp0_result, 32'd123);
      check("bp_req1_ready", 32'(req1_ready), 0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp0_ready = 1'b0;
    #1;
    check("bp_req1_granted", 32'(req1_ready), 1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    for (int c = 0; c < 8 && !rsp1_valid; c++) @(negedge clk);
    check("bp_rsp1_result", rsp1_result, 32'd2);
    rsp1_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp1_ready = 1'b0;

    // Reset while the op sits in WAIT.
    req0_valid = 1'b1; req0_op = ADD; req0_a = 32'd9; req0_b = 32'd9;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_l = 1'b0;
    #1;
    ap_bits = bmu_ap;
    check("mid_rst_valids", 32'({rsp0_valid, rsp1_valid, bmu_valid_in, req0_ready, req1_ready}), 0);
    check("mid_rst_operands", bmu_a_in | bmu_b_in, 0);
    check("mid_rst_ap", 32'(ap_bits), 0);
    check("mid_rst_resp", rsp0_result | 32'(rsp0_error), 0);
    @(negedge clk);
    rst_l = 1'b1;
    hits = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bmu_valid_in || rsp0_valid || rsp1_valid) hits++;
      @(negedge clk);
    end
    check("post_rst_quiet", hits, 0);
    v = '{1, ADD, 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b1, 20'h80001};
    do_op(v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
